// File: rtl/moving_avg_filter_if.sv
// Stream bundle for moving_avg_filter: sample input, averaged output, flush and primed status.
// The master side feeds samples and consumes results; the slave side is the filter.
interface moving_avg_filter_if #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 2
);
  logic                      clear;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      primed;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, primed
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, primed
  );
endinterface

// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar filter using a running sum over the last 2**LOG2_DEPTH samples.
// Define MOVING_AVG_ROUND_EN for round-half-up output with saturation; otherwise the output is floored.
module moving_avg_filter #(
  parameter int WIDTH      = 24,
  parameter int LOG2_DEPTH = 3,
  parameter int CHANNELS   = 2
) (
  input logic             clk,
  input logic             reset,
  moving_avg_filter_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;

  logic signed [WIDTH-1:0] hist     [CHANNELS][DEPTH];
  logic signed [SW-1:0]    sum      [CHANNELS];
  logic signed [SW-1:0]    sum_next [CHANNELS];
  logic signed [WIDTH-1:0] avg      [CHANNELS];
  logic [LOG2_DEPTH-1:0]   ptr;
  logic [LOG2_DEPTH:0]     fill_cnt;
  logic                    accept;

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.clear;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef MOVING_AVG_ROUND_EN
  localparam int HALF = 1 << (LOG2_DEPTH - 1);
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  logic signed [SW:0] rounded [CHANNELS];
`endif

  // The sum window never exceeds DEPTH full-scale samples, so SW bits cannot overflow.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_next[c] = sum[c] + SW'($signed(bus.in_data[c*WIDTH +: WIDTH])) - SW'(hist[c][ptr]);
`ifdef MOVING_AVG_ROUND_EN
      rounded[c] = ((SW+1)'(sum_next[c]) + (SW+1)'(HALF)) >>> LOG2_DEPTH;
      avg[c]     = (rounded[c] > (SW+1)'(MAXV)) ? MAXV : WIDTH'(rounded[c]);
`else
      avg[c]     = WIDTH'(sum_next[c] >>> LOG2_DEPTH);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c] <= '0;
        for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
      end
      ptr           <= '0;
      fill_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.primed    <= 1'b0;
    end else if (bus.clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c] <= '0;
        for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
      end
      ptr           <= '0;
      fill_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.primed    <= 1'b0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]                          <= sum_next[c];
        hist[c][ptr]                    <= $signed(bus.in_data[c*WIDTH +: WIDTH]);
        bus.out_data[c*WIDTH +: WIDTH]  <= avg[c];
      end
      ptr           <= ptr + 1'b1;
      bus.out_valid <= 1'b1;
      // primed rises together with the output of the DEPTH-th accepted sample.
      if (fill_cnt != (LOG2_DEPTH+1)'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
      if (fill_cnt >= (LOG2_DEPTH+1)'(DEPTH - 1)) bus.primed <= 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter (WIDTH=24, LOG2_DEPTH=3, CHANNELS=2).
// Expectations follow MOVING_AVG_ROUND_EN when it is defined.
module tb_moving_avg_filter;
  logic clk;
  logic reset;
  int   checks;
  int   passes;
  int   acc_count;

  moving_avg_filter_if #(.WIDTH(24), .CHANNELS(2)) bus ();

  moving_avg_filter #(.WIDTH(24), .LOG2_DEPTH(3), .CHANNELS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Independent tally of handshakes seen on the input side.
  always @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) acc_count++;
  end

  task automatic send(input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {b, a};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else passes++;
    checks++;
    if (bus.out_data !== 48'h0) $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data);
    else passes++;
    checks++;
    if (bus.primed !== 1'b0) $display("[TB] FAIL reset_primed: got %b expected 0", bus.primed);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else passes++;
  endtask

  task automatic test_ramp();
    logic [23:0] exp0 [8];
    logic        exp_primed;
`ifdef MOVING_AVG_ROUND_EN
    exp0 = '{24'd0, 24'd0, 24'd1, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5};
`else
    exp0 = '{24'd0, 24'd0, 24'd0, 24'd1, 24'd1, 24'd2, 24'd3, 24'd4};
`endif
    for (int i = 0; i < 8; i++) begin
      send(24'(i + 1), 24'd0);
      exp_primed = (i == 7);
      checks++;
      if (bus.out_data[23:0] !== exp0[i])
        $display("[TB] FAIL ramp_ch0[%0d]: got %0d expected %0d", i, bus.out_data[23:0], exp0[i]);
      else passes++;
      checks++;
      if (bus.out_data[47:24] !== 24'd0)
        $display("[TB] FAIL ramp_ch1[%0d]: got %h expected 0", i, bus.out_data[47:24]);
      else passes++;
      checks++;
      if (bus.primed !== exp_primed)
        $display("[TB] FAIL ramp_primed[%0d]: got %b expected %b", i, bus.primed, exp_primed);
      else passes++;
    end
  endtask

  task automatic test_negative();
    logic [23:0] exp1;
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send(24'd0, 24'hFFFFFF);
`ifdef MOVING_AVG_ROUND_EN
      exp1 = (i < 4) ? 24'h000000 : 24'hFFFFFF;
`else
      exp1 = 24'hFFFFFF;
`endif
      checks++;
      if (bus.out_data[47:24] !== exp1)
        $display("[TB] FAIL neg_ch1[%0d]: got %h expected %h", i, bus.out_data[47:24], exp1);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send(24'd8, 24'd0);
      checks++;
      if (bus.out_data[23:0] !== 24'(i + 1))
        $display("[TB] FAIL wrap_fill[%0d]: got %0d expected %0d", i, bus.out_data[23:0], i + 1);
      else passes++;
    end
    send(24'd0, 24'd0);
    checks++;
    if (bus.out_data[23:0] !== 24'd7) $display("[TB] FAIL wrap_first0: got %0d expected 7", bus.out_data[23:0]);
    else passes++;
    send(24'd0, 24'd0);
    checks++;
    if (bus.out_data[23:0] !== 24'd6) $display("[TB] FAIL wrap_second0: got %0d expected 6", bus.out_data[23:0]);
    else passes++;
    checks++;
    if (dut.ptr !== 3'd2) $display("[TB] FAIL wrap_ptr: got %0d expected 2", dut.ptr);
    else passes++;
  endtask

  task automatic test_extremes();
    logic [23:0] exp_first;
`ifdef MOVING_AVG_ROUND_EN
    exp_first = 24'h100000;
`else
    exp_first = 24'h0FFFFF;
`endif
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send(24'h7FFFFF, 24'h7FFFFF);
      if (i == 0) begin
        checks++;
        if (bus.out_data[23:0] !== exp_first)
          $display("[TB] FAIL ext_pos_first: got %h expected %h", bus.out_data[23:0], exp_first);
        else passes++;
      end
    end
    checks++;
    if (bus.out_data !== {24'h7FFFFF, 24'h7FFFFF})
      $display("[TB] FAIL ext_pos_final: got %h expected 7fffff7fffff", bus.out_data);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      send(24'h800000, 24'h800000);
      if (i == 0) begin
        checks++;
        if (bus.out_data[23:0] !== 24'h5FFFFF)
          $display("[TB] FAIL ext_neg_first: got %h expected 5fffff", bus.out_data[23:0]);
        else passes++;
      end
    end
    checks++;
    if (bus.out_data !== {24'h800000, 24'h800000})
      $display("[TB] FAIL ext_neg_final: got %h expected 800000800000", bus.out_data);
    else passes++;
    checks++;
    if (bus.primed !== 1'b1) $display("[TB] FAIL ext_primed: got %b expected 1", bus.primed);
    else passes++;
  endtask

  task automatic test_backpressure();
    int start;
    do_clear();
    @(negedge clk);
    start         = acc_count;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {24'd0, 24'd8};
    @(posedge clk);
    #1;
    bus.in_data = {24'd0, 24'd16};
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== {24'd0, 24'd1})
      $display("[TB] FAIL bp_first: got valid=%b data=%h expected valid=1 data=000000000001", bus.out_valid, bus.out_data);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_data !== {24'd0, 24'd1} || bus.out_valid !== 1'b1)
        $display("[TB] FAIL bp_stall[%0d]: got ready=%b valid=%b data=%h expected ready=0 valid=1 data=000000000001",
                 i, bus.in_ready, bus.out_valid, bus.out_data);
      else passes++;
    end
    checks++;
    if (acc_count - start !== 1) $display("[TB] FAIL bp_accepted: got %0d expected 1", acc_count - start);
    else passes++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data[23:0] !== 24'd3 || bus.out_valid !== 1'b1)
      $display("[TB] FAIL bp_release: got valid=%b ch0=%0d expected valid=1 ch0=3", bus.out_valid, bus.out_data[23:0]);
    else passes++;
    checks++;
    if (acc_count - start !== 2) $display("[TB] FAIL bp_total: got %0d expected 2", acc_count - start);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b expected 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_clear_reset();
    int start;
    do_clear();
    for (int i = 0; i < 9; i++) send(24'd8, 24'd0);
    checks++;
    if (bus.primed !== 1'b1) $display("[TB] FAIL cr_primed_before: got %b expected 1", bus.primed);
    else passes++;
    @(negedge clk);
    start        = acc_count;
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = {24'd0, 24'd50};
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0)
      $display("[TB] FAIL cr_clear: got valid=%b primed=%b expected 0 0", bus.out_valid, bus.primed);
    else passes++;
    checks++;
    if (acc_count - start !== 0) $display("[TB] FAIL cr_dropped: got %0d accepted expected 0", acc_count - start);
    else passes++;
    send(24'd8, 24'd0);
    checks++;
    if (bus.out_data[23:0] !== 24'd1 || bus.primed !== 1'b0)
      $display("[TB] FAIL cr_after_clear: got ch0=%0d primed=%b expected ch0=1 primed=0", bus.out_data[23:0], bus.primed);
    else passes++;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {24'd0, 24'd8};
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 48'h0 || bus.primed !== 1'b0)
      $display("[TB] FAIL cr_async_reset: got valid=%b data=%h primed=%b expected all 0", bus.out_valid, bus.out_data, bus.primed);
    else passes++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("[TB] FAIL cr_post_reset: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    else passes++;
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    checks        = 0;
    passes        = 0;
    acc_count     = 0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ramp();
    test_negative();
    test_wrap();
    test_extremes();
    test_backpressure();
    test_clear_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
